// File: rtl/sp_if_out_ddr_mc_if.sv
// Avalon-ST write-packet channel between the SP output buffer (master) and the DDR3 write master (slave).
`timescale 1ns/1ps
interface sp_if_out_ddr_mc_if #(
   parameter int OUT_W = 128
);
   logic             o_wr_valid;
   logic [OUT_W-1:0] o_wr_data;
   logic             o_wr_sop;
   logic             o_wr_eop;
   logic             o_wr_first;
   logic             o_wr_last;
   logic             i_wr_ready;

   modport master (
      output o_wr_valid, o_wr_data, o_wr_sop, o_wr_eop, o_wr_first, o_wr_last,
      input  i_wr_ready
   );
   modport slave (
      input  o_wr_valid, o_wr_data, o_wr_sop, o_wr_eop, o_wr_first, o_wr_last,
      output i_wr_ready
   );
endinterface

// File: rtl/sp_if_out_ddr_mc.sv
// Multi-channel SP result packer and DDR3 write-packet generator (one RAM region per channel).
// Optional stall-cycle counter port o_stall_cnt is enabled by defining SP_IF_OUT_STALL_CNT_EN.
`timescale 1ns/1ps
module sp_if_out_ddr_mc #(
   parameter int N_CH      = 2,
   parameter int IN_W      = 32,
   parameter int OUT_W     = 128,
   parameter int DEPTH     = 2048,
   parameter int START_DLY = 2048
) (
   input  logic                   i_clk156m,
   input  logic                   i_arst_n,
   input  logic                   i_ctrl_startp,
   input  logic                   i_ddr_wr_startp,
   input  logic [31:0]            i_ddr_size,
   input  logic [N_CH*IN_W-1:0]   i_ch_wr_data,
   input  logic [N_CH-1:0]        i_ch_wr_valid,
   sp_if_out_ddr_mc_if.master     wr,
   output logic                   o_busy,
   output logic                   o_err_size,
   output logic                   o_wr_ovf
`ifdef SP_IF_OUT_STALL_CNT_EN
   ,
   output logic [31:0]            o_stall_cnt
`endif
);
   // state | meaning
   // IDLE  | waiting for i_ddr_wr_startp
   // DLY   | start delay down-counter running; length sampled on expiry
   // LEN   | length check: error pulse, empty request returns to IDLE
   // RUN   | reading regions ch0..chN-1 into the skid buffer, until EOP accepted
   typedef enum logic [1:0] {ST_IDLE, ST_DLY, ST_LEN, ST_RUN} state_t;

   localparam int R   = OUT_W / IN_W;
   localparam int PW  = (R > 1) ? $clog2(R) : 1;
   localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int DW  = (START_DLY > 1) ? $clog2(START_DLY) : 1;
   localparam int BSH = $clog2(OUT_W / 8);
   localparam int EW  = OUT_W + 2;

   localparam logic [PW-1:0] PCNT_LAST = PW'(R - 1);
   localparam logic [PW-1:0] PCNT_ONE  = PW'(1);
   localparam logic [AW:0]   PTR_FULL  = (AW+1)'(DEPTH);
   localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
   localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
   localparam logic [CW-1:0] CH_ONE    = CW'(1);
   localparam logic [CW-1:0] CH_LAST   = CW'(N_CH - 1);
   localparam logic [DW-1:0] DLY_LOAD  = DW'(START_DLY - 1);
   localparam logic [DW-1:0] DLY_ONE   = DW'(1);

   state_t            state_q, state_d;
   logic [DW-1:0]     dly_q, dly_d;
   logic [AW:0]       len_q, len_d;
   logic              lerr_q, lerr_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;
   logic              pend_q, pend_d;
   logic              ovf_q, ovf_d;
   logic [CW-1:0]     rd_ch_q, rd_ch_d;
   logic [AW-1:0]     rd_addr_q, rd_addr_d;
   logic              rd_done_q, rd_done_d;
   logic              ram_v_q, ram_sop_q, ram_eop_q;
   logic [CW-1:0]     ram_ch_q;
   logic [1:0]        cnt_q, cnt_d;
   logic [EW-1:0]     e0_q, e0_d, e1_q, e1_d;
   logic              valid_q, valid_d;

   logic              clr, pop, push, rd_en, last_addr, credit_ok;
   logic [31:0]       l_raw;
   logic [N_CH-1:0]   drop;
   logic [OUT_W-1:0]  ram_dout [N_CH];
   logic [EW-1:0]     in_ent;

   // A clear requested during a transfer waits until the FSM is back in IDLE.
   assign clr = (state_q == ST_IDLE) && (i_ctrl_startp || pend_q);

   genvar k;
   generate
      for (k = 0; k < N_CH; k++) begin : g_ch
         logic [OUT_W-1:0] mem [DEPTH];
         logic [OUT_W-1:0] pack_q, pack_d, word;
         logic [PW-1:0]    pcnt_q, pcnt_d;
         logic [AW:0]      wptr_q, wptr_d;
         logic [OUT_W-1:0] dout_q;
         logic             we, drop_k;

         always_comb begin
            pack_d = pack_q;
            pcnt_d = pcnt_q;
            wptr_d = wptr_q;
            word   = pack_q;
            we     = 1'b0;
            drop_k = 1'b0;
            if (clr) begin
               pack_d = '0;
               pcnt_d = '0;
               wptr_d = '0;
            end else if (i_ch_wr_valid[k]) begin
               if (wptr_q == PTR_FULL) begin
                  drop_k = 1'b1;
               end else begin
                  word[int'(pcnt_q)*IN_W +: IN_W] = i_ch_wr_data[k*IN_W +: IN_W];
                  if (pcnt_q == PCNT_LAST) begin
                     we     = 1'b1;
                     wptr_d = wptr_q + PTR_ONE;
                     pcnt_d = '0;
                     pack_d = '0;
                  end else begin
                     pack_d = word;
                     pcnt_d = pcnt_q + PCNT_ONE;
                  end
               end
            end
         end

         always_ff @(posedge i_clk156m or negedge i_arst_n) begin
            if (!i_arst_n) begin
               pack_q <= '0;
               pcnt_q <= '0;
               wptr_q <= '0;
            end else begin
               pack_q <= pack_d;
               pcnt_q <= pcnt_d;
               wptr_q <= wptr_d;
            end
         end

         always_ff @(posedge i_clk156m) begin
            if (we)
               mem[wptr_q[AW-1:0]] <= word;
            if (rd_en && (rd_ch_q == CW'(k)))
               dout_q <= mem[rd_addr_q];
         end

         assign drop[k]     = drop_k;
         assign ram_dout[k] = dout_q;
      end
   endgenerate

   assign pop       = valid_q && wr.i_wr_ready;
   assign push      = ram_v_q;
   assign l_raw     = i_ddr_size >> BSH;
   assign last_addr = ({1'b0, rd_addr_q} == (len_q - PTR_ONE));
   // Count in-flight RAM data against skid space, crediting the beat leaving this cycle.
   assign credit_ok = (({1'b0, cnt_q}) + {2'b00, ram_v_q}) < (3'd2 + {2'b00, pop});
   assign rd_en     = (state_q == ST_RUN) && !rd_done_q && credit_ok;
   assign in_ent    = {ram_sop_q, ram_eop_q, ram_dout[ram_ch_q]};

   always_comb begin
      state_d   = state_q;
      dly_d     = dly_q;
      len_d     = len_q;
      lerr_d    = lerr_q;
      err_d     = 1'b0;
      rd_ch_d   = rd_ch_q;
      rd_addr_d = rd_addr_q;
      rd_done_d = rd_done_q;
      pend_d    = pend_q;
      ovf_d     = clr ? 1'b0 : (ovf_q | (|drop));

      if (state_q == ST_IDLE)
         pend_d = 1'b0;
      else if (i_ctrl_startp)
         pend_d = 1'b1;

      case (state_q)
         ST_IDLE: begin
            rd_ch_d   = '0;
            rd_addr_d = '0;
            rd_done_d = 1'b0;
            if (i_ddr_wr_startp) begin
               state_d = ST_DLY;
               dly_d   = DLY_LOAD;
            end
         end
         ST_DLY: begin
            if (dly_q == '0) begin
               state_d = ST_LEN;
               lerr_d  = (l_raw == '0) || (l_raw > 32'(DEPTH));
               len_d   = (l_raw > 32'(DEPTH)) ? PTR_FULL : l_raw[AW:0];
            end else begin
               dly_d = dly_q - DLY_ONE;
            end
         end
         ST_LEN: begin
            err_d   = lerr_q;
            state_d = (len_q == '0) ? ST_IDLE : ST_RUN;
         end
         ST_RUN: begin
            if (rd_en) begin
               if (last_addr) begin
                  rd_addr_d = '0;
                  if (rd_ch_q == CH_LAST)
                     rd_done_d = 1'b1;
                  else
                     rd_ch_d = rd_ch_q + CH_ONE;
               end else begin
                  rd_addr_d = rd_addr_q + ADDR_ONE;
               end
            end
            if (pop && e0_q[OUT_W])
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_comb begin
      e0_d  = e0_q;
      e1_d  = e1_q;
      cnt_d = cnt_q;
      if (pop) begin
         e0_d  = e1_q;
         cnt_d = cnt_q - 2'd1;
      end
      if (push) begin
         if (cnt_d == 2'd0)
            e0_d = in_ent;
         else
            e1_d = in_ent;
         cnt_d = cnt_d + 2'd1;
      end
      valid_d = (cnt_d != 2'd0);
   end

   always_ff @(posedge i_clk156m or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state_q   <= ST_IDLE;
         dly_q     <= '0;
         len_q     <= '0;
         lerr_q    <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         pend_q    <= 1'b0;
         ovf_q     <= 1'b0;
         rd_ch_q   <= '0;
         rd_addr_q <= '0;
         rd_done_q <= 1'b0;
         ram_v_q   <= 1'b0;
         ram_sop_q <= 1'b0;
         ram_eop_q <= 1'b0;
         ram_ch_q  <= '0;
         cnt_q     <= '0;
         e0_q      <= '0;
         e1_q      <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         dly_q     <= dly_d;
         len_q     <= len_d;
         lerr_q    <= lerr_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
         pend_q    <= pend_d;
         ovf_q     <= ovf_d;
         rd_ch_q   <= rd_ch_d;
         rd_addr_q <= rd_addr_d;
         rd_done_q <= rd_done_d;
         ram_v_q   <= rd_en;
         ram_sop_q <= rd_en && (rd_ch_q == '0) && (rd_addr_q == '0);
         ram_eop_q <= rd_en && (rd_ch_q == CH_LAST) && last_addr;
         ram_ch_q  <= rd_ch_q;
         cnt_q     <= cnt_d;
         e0_q      <= e0_d;
         e1_q      <= e1_d;
         valid_q   <= valid_d;
      end
   end

   assign wr.o_wr_valid = valid_q;
   assign wr.o_wr_data  = e0_q[OUT_W-1:0];
   assign wr.o_wr_sop   = valid_q && e0_q[OUT_W+1];
   assign wr.o_wr_eop   = valid_q && e0_q[OUT_W];
   assign wr.o_wr_first = valid_q && e0_q[OUT_W+1];
   assign wr.o_wr_last  = valid_q && e0_q[OUT_W];
   assign o_busy        = busy_q;
   assign o_err_size    = err_q;
   assign o_wr_ovf      = ovf_q;

`ifdef SP_IF_OUT_STALL_CNT_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if ((state_q == ST_DLY) && (dly_q == '0))
         stall_d = '0;
      else if ((state_q == ST_RUN) && valid_q && !wr.i_wr_ready && (stall_q != 32'hFFFF_FFFF))
         stall_d = stall_q + 32'd1;
   end

   always_ff @(posedge i_clk156m or negedge i_arst_n) begin
      if (!i_arst_n)
         stall_q <= '0;
      else
         stall_q <= stall_d;
   end

   assign o_stall_cnt = stall_q;
`else
   // Stall counter not built.
`endif

endmodule

// File: tb/tb_sp_if_out_ddr_mc.sv
// Scoreboard bench for sp_if_out_ddr_mc: stimulus pushes expected beats, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_sp_if_out_ddr_mc;
   localparam int N_CH = 2, IN_W = 32, OUT_W = 128, DEPTH = 8, START_DLY = 4;

   typedef struct packed {
      logic [OUT_W-1:0] d;
      logic             sop;
      logic             eop;
   } beat_t;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 ctrl_startp, ddr_startp;
   logic [31:0]          ddr_size;
   logic [N_CH*IN_W-1:0] ch_data;
   logic [N_CH-1:0]      ch_valid;
   logic                 busy, err_size, ovf;
`ifdef SP_IF_OUT_STALL_CNT_EN
   logic [31:0]          stall_cnt;
`endif

   sp_if_out_ddr_mc_if #(.OUT_W(OUT_W)) wr_if ();

   sp_if_out_ddr_mc #(
      .N_CH(N_CH), .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .START_DLY(START_DLY)
   ) dut (
      .i_clk156m      (clk),
      .i_arst_n       (rst_n),
      .i_ctrl_startp  (ctrl_startp),
      .i_ddr_wr_startp(ddr_startp),
      .i_ddr_size     (ddr_size),
      .i_ch_wr_data   (ch_data),
      .i_ch_wr_valid  (ch_valid),
      .wr             (wr_if),
      .o_busy         (busy),
      .o_err_size     (err_size),
      .o_wr_ovf       (ovf)
`ifdef SP_IF_OUT_STALL_CNT_EN
      ,
      .o_stall_cnt    (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   beat_t exp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    beats_seen = 0;
   int    err_cnt = 0;
   int    valid_cnt = 0;

   task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // Monitor: beat scoreboard plus hold-stability under backpressure.
   initial begin : monitor
      beat_t            e;
      logic [OUT_W-1:0] held = '0;
      logic             hold_v = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (err_size) err_cnt++;
            if (wr_if.o_wr_valid) valid_cnt++;
            if (hold_v) begin
               chk("hold_valid", {127'd0, wr_if.o_wr_valid}, 128'd1);
               chk("hold_data", wr_if.o_wr_data, held);
            end
            hold_v = 1'b0;
            if (wr_if.o_wr_valid && !wr_if.i_wr_ready) begin
               hold_v = 1'b1;
               held   = wr_if.o_wr_data;
            end else if (wr_if.o_wr_valid && wr_if.i_wr_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat: got data %h, required no beat", wr_if.o_wr_data);
               end else begin
                  e = exp_q.pop_front();
                  chk("beat_data", wr_if.o_wr_data, e.d);
                  chk("beat_sop", {127'd0, wr_if.o_wr_sop}, {127'd0, e.sop});
                  chk("beat_first", {127'd0, wr_if.o_wr_first}, {127'd0, e.sop});
                  chk("beat_eop", {127'd0, wr_if.o_wr_eop}, {127'd0, e.eop});
                  chk("beat_last", {127'd0, wr_if.o_wr_last}, {127'd0, e.eop});
                  beats_seen++;
               end
            end
         end else begin
            hold_v = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
      ch_data  = {b, a};
      ch_valid = m;
      tick();
      ch_valid = '0;
   endtask

   task automatic fill(input logic [31:0] b0, input logic [31:0] b1, input int n);
      for (int i = 0; i < n; i++) wr(b0 + 32'(i), b1 + 32'(i), 2'b11);
   endtask

   // Expected packet: ch0 words 0..L-1, then ch1 words 0..L-1; word w holds inputs 4w..4w+3.
   task automatic push_pkt(input logic [31:0] b0, input logic [31:0] b1, input int l);
      beat_t e;
      for (int c = 0; c < N_CH; c++) begin
         for (int w = 0; w < l; w++) begin
            for (int j = 0; j < 4; j++)
               e.d[j*32 +: 32] = ((c == 0) ? b0 : b1) + 32'(4*w + j);
            e.sop = (c == 0) && (w == 0);
            e.eop = (c == N_CH-1) && (w == l-1);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic start(input logic [31:0] size);
      ddr_size   = size;
      ddr_startp = 1'b1;
      tick();
      ddr_startp = 1'b0;
   endtask

   task automatic pulse_ctrl();
      ctrl_startp = 1'b1;
      tick();
      ctrl_startp = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < 400) begin
         tick();
         n++;
      end
      chk({name, "_complete"}, {127'd0, (n < 400)}, 128'd1);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!wr_if.o_wr_valid && n < 50) begin
         tick();
         n++;
      end
   endtask

   initial begin : stim
      int n, e0, v0, stalls, b0;
      ctrl_startp = 1'b0;
      ddr_startp  = 1'b0;
      ddr_size    = '0;
      ch_data     = '0;
      ch_valid    = '0;
      wr_if.i_wr_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {127'd0, wr_if.o_wr_valid}, 128'd0);
      chk("rst_busy", {127'd0, busy}, 128'd0);
      chk("rst_err", {127'd0, err_size}, 128'd0);
      chk("rst_ovf", {127'd0, ovf}, 128'd0);
      chk("rst_sop_eop", {126'd0, wr_if.o_wr_sop, wr_if.o_wr_eop}, 128'd0);
      chk("rst_data", wr_if.o_wr_data, 128'd0);
      rst_n = 1'b1;
      tick();

      // Basic packet and start-to-valid latency.
      fill(32'h0, 32'h100, 8);
      push_pkt(32'h0, 32'h100, 2);
      start(32);
      n = 1;
      while (n <= 50) begin
         tick();
         if (wr_if.o_wr_valid) break;
         n++;
      end
      chk("start_latency", 128'(n), 128'(START_DLY + 3));
      wait_done("basic");
      chk("basic_busy_low", {127'd0, busy}, 128'd0);

      // Backpressure with ready pattern 1,0,0,1,0,0,...
      push_pkt(32'h0, 32'h100, 2);
      stalls = 0;
      start(32);
      n = 0;
      while ((busy || exp_q.size() != 0) && n < 400) begin
         wr_if.i_wr_ready = (n % 3 == 0);
         @(negedge clk);
         if (wr_if.o_wr_valid && !wr_if.i_wr_ready) stalls++;
         @(posedge clk);
         #1;
         n++;
      end
      wr_if.i_wr_ready = 1'b1;
      chk("bp_complete", {127'd0, (n < 400)}, 128'd1);
`ifdef SP_IF_OUT_STALL_CNT_EN
      chk("stall_cnt", 128'(stall_cnt), 128'(stalls));
`endif

      // Size 0: error pulse, no beats.
      e0 = err_cnt;
      v0 = valid_cnt;
      start(0);
      wait_done("size0");
      repeat (5) tick();
      chk("size0_err_pulse", 128'(err_cnt - e0), 128'd1);
      chk("size0_no_valid", 128'(valid_cnt - v0), 128'd0);

      // Size 16: one word per channel.
      e0 = err_cnt;
      push_pkt(32'h0, 32'h100, 1);
      start(16);
      wait_done("size16");
      chk("size16_no_err", 128'(err_cnt - e0), 128'd0);

      // Second DDR request mid-packet is ignored.
      push_pkt(32'h0, 32'h100, 2);
      start(32);
      wait_valid(n);
      ddr_startp = 1'b1;
      tick();
      ddr_startp = 1'b0;
      wait_done("ddr_start_ignored");
      v0 = valid_cnt;
      repeat (START_DLY + 10) tick();
      chk("ignored_busy", {127'd0, busy}, 128'd0);
      chk("ignored_no_valid", 128'(valid_cnt - v0), 128'd0);

      // Clear mid-packet: packet completes with old data, then pointers restart at 0.
      push_pkt(32'h0, 32'h100, 2);
      start(32);
      wait_valid(n);
      pulse_ctrl();
      wait_done("ctrl_mid");
      tick();
      tick();
      fill(32'h200, 32'h300, 8);
      push_pkt(32'h200, 32'h300, 2);
      start(32);
      wait_done("after_clear");

      // Overflow: fill both regions, one extra ch0 write; then clamped full read.
      pulse_ctrl();
      fill(32'h0, 32'h100, DEPTH * 4);
      chk("ovf_before", {127'd0, ovf}, 128'd0);
      wr(32'hDEAD, 32'h0, 2'b01);
      tick();
      chk("ovf_set", {127'd0, ovf}, 128'd1);
      e0 = err_cnt;
      push_pkt(32'h0, 32'h100, DEPTH);
      start((DEPTH + 1) * 16);
      wait_done("clamp");
      chk("clamp_err_pulse", 128'(err_cnt - e0), 128'd1);
      chk("ovf_sticky", {127'd0, ovf}, 128'd1);
      pulse_ctrl();
      tick();
      chk("ovf_cleared", {127'd0, ovf}, 128'd0);

      // Asynchronous reset mid-packet, then a clean packet.
      push_pkt(32'h0, 32'h100, DEPTH);
      b0 = beats_seen;
      start(DEPTH * 16);
      n = 0;
      while ((beats_seen - b0) < 3 && n < 100) begin
         tick();
         n++;
      end
      chk("rst_mid_progress", {127'd0, (n < 100)}, 128'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rstmid_valid", {127'd0, wr_if.o_wr_valid}, 128'd0);
      chk("rstmid_flags", {124'd0, wr_if.o_wr_sop, wr_if.o_wr_eop, wr_if.o_wr_first, wr_if.o_wr_last}, 128'd0);
      chk("rstmid_busy", {127'd0, busy}, 128'd0);
      chk("rstmid_data", wr_if.o_wr_data, 128'd0);
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      tick();
      fill(32'h400, 32'h500, 8);
      push_pkt(32'h400, 32'h500, 2);
      start(32);
      wait_done("after_reset");

      repeat (5) tick();
      chk("queue_empty", 128'(exp_q.size()), 128'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
